// File: rtl/ram2p1r1wbe_ctrl_pkg.sv
// Shared types for the 1R/1W byte-enable RAM controller: core configuration and FSM states.
package ram2p1r1wbe_ctrl_pkg;

    typedef struct packed {
        logic USE_SRAM;
    } cvw_t;

    typedef enum logic {
        RAMCTRL_INIT,
        RAMCTRL_READY
    } ramctrlstate_t;

endpackage

// File: rtl/ram2p1r1wbe_ctrl_if.sv
// Requester-side bus of the RAM controller: flush/init status, one read port, two write ports.
interface ram2p1r1wbe_ctrl_if #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 68,
    parameter int unsigned NBE   = (WIDTH - 1) / 8 + 1
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             flush;
    logic             init_done;
    logic             rd_req;
    logic [AW-1:0]    rd_adr;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [1:0]       wr_req;
    logic [1:0]       wr_gnt;
    logic [AW-1:0]    wr_adr0;
    logic [AW-1:0]    wr_adr1;
    logic [WIDTH-1:0] wr_data0;
    logic [WIDTH-1:0] wr_data1;
    logic [NBE-1:0]   wr_be0;
    logic [NBE-1:0]   wr_be1;

    modport master (
        output flush, rd_req, rd_adr, wr_req, wr_adr0, wr_adr1, wr_data0, wr_data1, wr_be0, wr_be1,
        input  init_done, rd_valid, rd_data, wr_gnt
    );

    modport slave (
        input  flush, rd_req, rd_adr, wr_req, wr_adr0, wr_adr1, wr_data0, wr_data1, wr_be0, wr_be1,
        output init_done, rd_valid, rd_data, wr_gnt
    );
endinterface

// File: rtl/openhw_ram2p1r1wbe.sv
// Behavioural 1R/1W RAM with byte write enables; synchronous read-first read port.
module openhw_ram2p1r1wbe
    import ram2p1r1wbe_ctrl_pkg::*;
#(
    parameter cvw_t        P     = '0,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 68,
    parameter int unsigned NBE   = (WIDTH - 1) / 8 + 1
) (
    input  logic                     clk,
    input  logic                     ce1,
    input  logic [$clog2(DEPTH)-1:0] ra1,
    output logic [WIDTH-1:0]         rd1,
    input  logic                     ce2,
    input  logic                     we2,
    input  logic [$clog2(DEPTH)-1:0] wa2,
    input  logic [WIDTH-1:0]         wd2,
    input  logic [NBE-1:0]           bwe2
);
    logic [WIDTH-1:0] mem [DEPTH];

    // SRAM macros take a bit-level write mask; the flop array writes lane by lane.
    if (P.USE_SRAM) begin : g_sram
        logic [WIDTH-1:0] w_bmask;
        always_comb begin
            w_bmask = '0;
            for (int b = 0; b < WIDTH; b++) w_bmask[b] = bwe2[b/8];
        end
        always_ff @(posedge clk) begin
            if (ce2 && we2) mem[wa2] <= (mem[wa2] & ~w_bmask) | (wd2 & w_bmask);
        end
    end else begin : g_flop
        always_ff @(posedge clk) begin
            if (ce2 && we2) begin
                for (int b = 0; b < WIDTH; b++) begin
                    if (bwe2[b/8]) mem[wa2][b] <= wd2[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce1) rd1 <= mem[ra1];
    end
endmodule

// File: rtl/ram2p1r1wbe_ctrl.sv
// RAM controller: clear-after-reset/flush, round-robin write arbitration, forwarded 1-cycle reads.
module ram2p1r1wbe_ctrl
    import ram2p1r1wbe_ctrl_pkg::*;
#(
    parameter cvw_t        P     = '0,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 68,
    parameter int unsigned NBE   = (WIDTH - 1) / 8 + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    ram2p1r1wbe_ctrl_if.slave   bus
);
    localparam int unsigned    AW      = $clog2(DEPTH);
    localparam logic [AW-1:0]  LastAdr = AW'(DEPTH - 1);

    ramctrlstate_t    r_state, w_state_nxt;
    logic [AW-1:0]    r_init_cnt, w_init_cnt_nxt;
    logic             r_rr, w_rr_nxt;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_fwd_hit;
    logic [WIDTH-1:0] r_fwd_data;
    logic [NBE-1:0]   r_fwd_be;

    logic [1:0]       w_gnt;
    logic             w_rd_acc;
    logic             w_ce2;
    logic [AW-1:0]    w_wa2;
    logic [WIDTH-1:0] w_wd2;
    logic [NBE-1:0]   w_bwe2;
    logic             w_fwd_hit;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_merged;

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_rr_nxt       = r_rr;
        w_gnt          = 2'b00;
        w_rd_acc       = 1'b0;
        w_ce2          = 1'b0;
        w_wa2          = r_init_cnt;
        w_wd2          = '0;
        w_bwe2         = '1;
        unique case (r_state)
            RAMCTRL_INIT: begin
                w_ce2          = 1'b1;
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == LastAdr) begin
                    w_state_nxt    = RAMCTRL_READY;
                    w_init_cnt_nxt = '0;
                end
            end
            RAMCTRL_READY: begin
                w_rd_acc = bus.rd_req;
                if (bus.flush) begin
                    w_state_nxt    = RAMCTRL_INIT;
                    w_init_cnt_nxt = '0;
                end else begin
                    case (bus.wr_req)
                        2'b01:   w_gnt = 2'b01;
                        2'b10:   w_gnt = 2'b10;
                        2'b11: begin
                            w_gnt    = r_rr ? 2'b10 : 2'b01;
                            w_rr_nxt = ~r_rr;
                        end
                        default: w_gnt = 2'b00;
                    endcase
                end
                if (w_gnt[1]) begin
                    w_ce2  = 1'b1;
                    w_wa2  = bus.wr_adr1;
                    w_wd2  = bus.wr_data1;
                    w_bwe2 = bus.wr_be1;
                end else if (w_gnt[0]) begin
                    w_ce2  = 1'b1;
                    w_wa2  = bus.wr_adr0;
                    w_wd2  = bus.wr_data0;
                    w_bwe2 = bus.wr_be0;
                end
            end
            default: ;
        endcase
    end

    // The RAM is read-first, so a same-cycle write to the read address must be merged afterwards.
    assign w_fwd_hit = w_rd_acc & w_ce2 & (w_wa2 == bus.rd_adr);

    always_comb begin
        w_merged = w_rd1;
        for (int b = 0; b < WIDTH; b++) begin
            if (r_fwd_hit && r_fwd_be[b/8]) w_merged[b] = r_fwd_data[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RAMCTRL_INIT;
            r_init_cnt <= '0;
            r_rr       <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
            r_fwd_be   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_rr       <= w_rr_nxt;
            r_rd_valid <= w_rd_acc;
            if (r_rd_valid) r_rd_data <= w_merged;
            if (w_rd_acc) begin
                r_fwd_hit  <= w_fwd_hit;
                r_fwd_data <= w_wd2;
                r_fwd_be   <= w_bwe2;
            end
        end
    end

    // r_rd_data only captures the merged word, so it holds the last result once reads stop.
    assign bus.init_done = (r_state == RAMCTRL_READY);
    assign bus.wr_gnt    = w_gnt;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_valid ? w_merged : r_rd_data;

    openhw_ram2p1r1wbe #(
        .P     (P),
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .NBE   (NBE)
    ) u_ram (
        .clk  (clk),
        .ce1  (w_rd_acc),
        .ra1  (bus.rd_adr),
        .rd1  (w_rd1),
        .ce2  (w_ce2),
        .we2  (w_ce2),
        .wa2  (w_wa2),
        .wd2  (w_wd2),
        .bwe2 (w_bwe2)
    );
endmodule
